// File: rtl/mips_fetch_pkg.sv
// -----------------------------------------------------------------------------
// mips_fetch_pkg
//   Shared types for the IFU fetch sequencer: the sequencer state encoding,
//   the default legal text-segment bounds, the fetch-exception flag bundle and
//   the address legality helper.
// -----------------------------------------------------------------------------
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // one dead cycle after reset before the first fetch
        ST_FETCH = 2'd1,  // request issued for the current PC
        ST_HOLD  = 2'd2,  // returned word parked while the pipeline stalls
        ST_DRAIN = 2'd3   // waiting out a stale request whose data is dropped
    } fetch_state_t;

    localparam logic [31:0] TEXT_BASE_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] TEXT_LIMIT_DEFAULT = 32'h0000_6FFC;

    localparam int WAIT_CNT_W = 8;

    typedef struct packed {
        logic adel;  // fetch address error
        logic ibe;   // fetch bus error (ack timeout)
    } fetch_exc_t;

    localparam fetch_exc_t EXC_NONE = '{adel: 1'b0, ibe: 1'b0};

    // Misaligned or outside the inclusive [base, limit] window.
    function automatic logic fetch_addr_bad(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] limit
    );
        return (addr[1:0] != 2'b00) || (addr < base) || (addr > limit);
    endfunction

endpackage

// File: rtl/ifu_fetch_buf.sv
// -----------------------------------------------------------------------------
// ifu_fetch_buf
//   One-entry holding buffer for a fetched instruction and its exception flags,
//   used while the F/D register is stalled.
//
//   clk        in   clock, rising edge
//   RESET_N    in   synchronous active-low reset (clears valid only)
//   load       in   capture load_instr/load_exc and set valid
//   clear      in   invalidate the entry (wins over load)
//   load_instr in   instruction word to capture
//   load_exc   in   exception flags to capture
//   valid      out  entry holds a word
//   instr      out  buffered instruction
//   exc        out  buffered exception flags
// -----------------------------------------------------------------------------
module ifu_fetch_buf
    import mips_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        RESET_N,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  fetch_exc_t  load_exc,
    output logic        valid,
    output logic [31:0] instr,
    output fetch_exc_t  exc
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples its inputs from before the edge, regardless of block order.
    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // NOTE: the data registers carry no reset; valid alone qualifies them, so
    // resetting the payload would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (load && !clear) begin
            instr <= load_instr;
            exc   <= load_exc;
        end
    end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// ifu_fetch_ctrl
//   Fetch sequencer between the IFU PC, a variable-latency instruction memory
//   (req/ack) and the F/D pipeline register. Holds the PC until a fetch returns,
//   parks a returned word while the pipeline stalls, drains stale requests after
//   a redirect or timeout, and flags address and bus errors.
//
//   clk         in   clock, rising edge
//   RESET_N     in   synchronous active-low reset
//   PIPE_STALL  in   hazard stall; F/D must hold
//   Req         in   exception/interrupt redirect
//   ERET        in   ERET redirect
//   InstrAddr   in   current PC from the IFU
//   STALL_EN_N  out  PC write enable (1 = PC loads NPC this edge)
//   im_req      out  fetch request
//   im_addr     out  fetch address, stable while a request is outstanding
//   im_ack      in   fetch done (may coincide with the first im_req cycle)
//   im_rdata    in   fetched word, valid with im_ack
//   F_valid     out  F_instr is a real instruction
//   F_instr     out  instruction to F/D
//   F_exc_adel  out  fetch address error
//   F_exc_ibe   out  fetch bus error (ack timeout)
// -----------------------------------------------------------------------------
module ifu_fetch_ctrl
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE  = TEXT_BASE_DEFAULT,
    parameter logic [31:0] TEXT_LIMIT = TEXT_LIMIT_DEFAULT,
    parameter int          TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic        PIPE_STALL,
    input  logic        Req,
    input  logic        ERET,
    input  logic [31:0] InstrAddr,
    output logic        STALL_EN_N,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic        F_valid,
    output logic [31:0] F_instr,
    output logic        F_exc_adel,
    output logic        F_exc_ibe
);

    // The timeout fires on the cycle the count of unanswered request cycles
    // would reach TIMEOUT, so TIMEOUT=1 errors on the first silent cycle.
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

    fetch_state_t          state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]           addr_q;

    logic redirect;
    logic addr_bad;
    logic timeout_hit;

    logic        buf_load, buf_clear;
    logic [31:0] buf_load_instr;
    fetch_exc_t  buf_load_exc;
    logic        buf_valid;
    logic [31:0] buf_instr;
    fetch_exc_t  buf_exc;

    assign redirect    = Req | ERET;
    assign addr_bad    = fetch_addr_bad(InstrAddr, TEXT_BASE, TEXT_LIMIT);
    assign timeout_hit = (wait_cnt_q == TIMEOUT_LAST);

    ifu_fetch_buf u_buf (
        .clk        (clk),
        .RESET_N    (RESET_N),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_instr (buf_load_instr),
        .load_exc   (buf_load_exc),
        .valid      (buf_valid),
        .instr      (buf_instr),
        .exc        (buf_exc)
    );

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // The PC is frozen while a request is open, so re-latching it every request
    // cycle leaves the start-of-request address here for DRAIN to replay.
    always_ff @(posedge clk) begin
        if (state_q == ST_FETCH && im_req) begin
            addr_q <= InstrAddr;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d        = state_q;
        wait_cnt_d     = '0;
        STALL_EN_N     = 1'b0;
        im_req         = 1'b0;
        im_addr        = '0;
        F_valid        = 1'b0;
        F_instr        = '0;
        F_exc_adel     = 1'b0;
        F_exc_ibe      = 1'b0;
        buf_load       = 1'b0;
        buf_clear      = 1'b0;
        buf_load_instr = '0;
        buf_load_exc   = EXC_NONE;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (redirect) begin
                    // Keep a good-address request up: if memory has not acked
                    // yet it is still in flight and must be drained.
                    STALL_EN_N = 1'b1;
                    buf_clear  = 1'b1;
                    if (!addr_bad) begin
                        im_req  = 1'b1;
                        im_addr = InstrAddr;
                        if (!im_ack) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end else if (addr_bad) begin
                    F_valid    = 1'b1;
                    F_exc_adel = 1'b1;
                    STALL_EN_N = !PIPE_STALL;
                end else begin
                    im_req  = 1'b1;
                    im_addr = InstrAddr;
                    if (im_ack) begin
                        F_valid = 1'b1;
                        F_instr = im_rdata;
                        if (PIPE_STALL) begin
                            buf_load       = 1'b1;
                            buf_load_instr = im_rdata;
                            state_d        = ST_HOLD;
                        end else begin
                            STALL_EN_N = 1'b1;
                        end
                    end else if (timeout_hit) begin
                        // Synthetic ack: deliver a bus-error bubble.
                        F_valid   = 1'b1;
                        F_exc_ibe = 1'b1;
                        if (PIPE_STALL) begin
                            buf_load         = 1'b1;
                            buf_load_exc.ibe = 1'b1;
                            state_d          = ST_HOLD;
                        end else begin
                            STALL_EN_N = 1'b1;
                            state_d    = ST_DRAIN;
                        end
                    end else begin
                        wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q
                                                        : wait_cnt_q + 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    STALL_EN_N = 1'b1;
                    buf_clear  = 1'b1;
                    state_d    = ST_FETCH;
                end else begin
                    F_valid    = buf_valid;
                    F_instr    = buf_instr;
                    F_exc_adel = buf_exc.adel;
                    F_exc_ibe  = buf_exc.ibe;
                    STALL_EN_N = !PIPE_STALL;
                    if (!PIPE_STALL) begin
                        buf_clear = 1'b1;
                        state_d   = ST_FETCH;
                    end
                end
            end

            ST_DRAIN: begin
                // Replay the original address so the memory sees a stable
                // request until it acks; the returned data is dropped.
                im_req  = 1'b1;
                im_addr = addr_q;
                if (redirect) begin
                    STALL_EN_N = 1'b1;
                    buf_clear  = 1'b1;
                end else if (im_ack) begin
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ifu_fetch_ctrl
//   Directed scenarios followed by randomized traffic. A responder plays the
//   instruction memory with per-request latency; a cycle-level reference model
//   built from the fetch rules predicts every output.
// -----------------------------------------------------------------------------
module tb_ifu_fetch_ctrl;
    import mips_fetch_pkg::*;

    localparam int          TMO   = 4;
    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam logic [31:0] LIMIT = 32'h0000_6FFC;
    localparam int          NO_ACK = 1000;

    logic        clk = 1'b0;
    logic        RESET_N;
    logic        PIPE_STALL, Req, ERET;
    logic [31:0] InstrAddr;
    logic        STALL_EN_N, im_req, im_ack;
    logic [31:0] im_addr, im_rdata;
    logic        F_valid, F_exc_adel, F_exc_ibe;
    logic [31:0] F_instr;

    int n_checks = 0;
    int n_errors = 0;
    int state_hits [4];

    always #5 clk = ~clk;

    ifu_fetch_ctrl #(
        .TEXT_BASE  (BASE),
        .TEXT_LIMIT (LIMIT),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .RESET_N    (RESET_N),
        .PIPE_STALL (PIPE_STALL),
        .Req        (Req),
        .ERET       (ERET),
        .InstrAddr  (InstrAddr),
        .STALL_EN_N (STALL_EN_N),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_ack     (im_ack),
        .im_rdata   (im_rdata),
        .F_valid    (F_valid),
        .F_instr    (F_instr),
        .F_exc_adel (F_exc_adel),
        .F_exc_ibe  (F_exc_ibe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- stimulus-side state ----------------
    logic [31:0] pc;
    logic [31:0] redir_target;
    logic        cur_redir;
    bit          fixed_valid = 1'b0;
    logic [31:0] fixed_data;
    bit          mem_busy;
    int          mem_left;
    logic [31:0] mem_data;

    // ---------------- reference model ----------------
    // Boolean phase flags: whether the first fetch may start, whether a word is
    // parked, whether a stale request is being waited out, and how many silent
    // cycles the current request has seen.
    bit          m_started, m_held, m_held_ibe, m_drain;
    logic [31:0] m_held_instr, m_drain_addr;
    int          m_waits;
    bit          n_started, n_held, n_held_ibe, n_drain;
    logic [31:0] n_held_instr, n_drain_addr;
    int          n_waits;
    bit          e_sen, e_req, e_valid, e_adel, e_ibe;
    logic [31:0] e_addr, e_instr;

    function automatic bit illegal_pc(input logic [31:0] a);
        return (a % 4 != 0) || (a < BASE) || (a > LIMIT);
    endfunction

    task automatic model_reset();
        m_started = 0; m_held = 0; m_held_ibe = 0; m_drain = 0; m_waits = 0;
        m_held_instr = '0; m_drain_addr = '0;
    endtask

    task automatic model_eval(input bit stall, input bit redir, input bit ack,
                              input logic [31:0] pc_v, input logic [31:0] rdata);
        e_sen = 0; e_req = 0; e_valid = 0; e_adel = 0; e_ibe = 0;
        e_addr = '0; e_instr = '0;
        n_started = m_started; n_held = m_held; n_held_ibe = m_held_ibe;
        n_drain = m_drain; n_held_instr = m_held_instr;
        n_drain_addr = m_drain_addr; n_waits = m_waits;

        if (!m_started) begin
            n_started = 1;
        end else if (m_drain) begin
            e_req  = 1;
            e_addr = m_drain_addr;
            e_sen  = redir;
            if (!redir && ack) n_drain = 0;
        end else if (m_held) begin
            if (redir) begin
                e_sen  = 1;
                n_held = 0;
            end else begin
                e_valid = 1;
                e_instr = m_held_instr;
                e_ibe   = m_held_ibe;
                e_sen   = !stall;
                if (!stall) n_held = 0;
            end
        end else if (illegal_pc(pc_v)) begin
            n_waits = 0;
            if (redir) begin
                e_sen = 1;
            end else begin
                e_valid = 1;
                e_adel  = 1;
                e_sen   = !stall;
            end
        end else begin
            e_req        = 1;
            e_addr       = pc_v;
            n_drain_addr = pc_v;
            n_waits      = 0;
            if (redir) begin
                e_sen = 1;
                if (!ack) n_drain = 1;
            end else if (ack) begin
                e_valid = 1;
                e_instr = rdata;
                if (!stall) e_sen = 1;
                else begin
                    n_held = 1; n_held_instr = rdata; n_held_ibe = 0;
                end
            end else if (m_waits + 1 == TMO) begin
                e_valid = 1;
                e_ibe   = 1;
                if (!stall) begin
                    e_sen = 1; n_drain = 1;
                end else begin
                    n_held = 1; n_held_instr = '0; n_held_ibe = 1;
                end
            end else begin
                n_waits = m_waits + 1;
            end
        end
    endtask

    // Drive one cycle's inputs, let the memory respond, then compare.
    task automatic drive_eval(input bit stall, input bit rq, input bit er, input int lat);
        PIPE_STALL = stall;
        Req        = rq;
        ERET       = er;
        InstrAddr  = pc;
        cur_redir  = rq | er;
        #1;
        if (im_req) begin
            if (!mem_busy) begin
                mem_busy = 1;
                mem_left = lat;
                mem_data = fixed_valid ? fixed_data : $urandom;
            end
            if (mem_left == 0) begin
                im_ack   = 1'b1;
                im_rdata = mem_data;
                mem_busy = 0;
            end else begin
                im_ack   = 1'b0;
                im_rdata = $urandom;
                mem_left--;
            end
        end else begin
            im_ack   = 1'b0;
            im_rdata = $urandom;
            mem_busy = 0;
        end
        #1;
        model_eval(stall, cur_redir, im_ack, pc, im_rdata);
        state_hits[int'(dut.state_q)]++;
        check("stall_en_n", 32'(STALL_EN_N), 32'(e_sen));
        check("im_req", 32'(im_req), 32'(e_req));
        if (e_req) check("im_addr", im_addr, e_addr);
        check("f_valid", 32'(F_valid), 32'(e_valid));
        if (e_valid) check("f_instr", F_instr, e_instr);
        check("f_exc_adel", 32'(F_exc_adel), 32'(e_adel));
        check("f_exc_ibe", 32'(F_exc_ibe), 32'(e_ibe));
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        m_started = n_started; m_held = n_held; m_held_ibe = n_held_ibe;
        m_drain = n_drain; m_held_instr = n_held_instr;
        m_drain_addr = n_drain_addr; m_waits = n_waits;
        if (e_sen) pc = cur_redir ? redir_target : pc + 32'd4;
    endtask

    task automatic step(input bit stall, input bit rq, input bit er, input int lat);
        drive_eval(stall, rq, er, lat);
        advance();
    endtask

    task automatic do_reset();
        RESET_N    = 1'b0;
        PIPE_STALL = 1'b0;
        Req        = 1'b0;
        ERET       = 1'b0;
        im_ack     = 1'b0;
        @(posedge clk);
        #1;
        check("rst_stall_en_n", 32'(STALL_EN_N), 32'd0);
        check("rst_im_req", 32'(im_req), 32'd0);
        check("rst_f_valid", 32'(F_valid), 32'd0);
        check("rst_f_instr", F_instr, 32'd0);
        check("rst_f_exc_adel", 32'(F_exc_adel), 32'd0);
        check("rst_f_exc_ibe", 32'(F_exc_ibe), 32'd0);
        model_reset();
        mem_busy = 0;
        pc       = BASE;
        RESET_N  = 1'b1;
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 9))
            0: return BASE;
            1: return LIMIT;
            2: return LIMIT - 32'd8;
            3: return LIMIT + 32'd4;
            4: return BASE - 32'd4;
            5: return BASE + 32'd2;
            6: return 32'h0000_0000;
            7: return BASE + 32'd1;
            default: return BASE + (32'($urandom_range(0, 4094)) << 2);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_pc;
        RESET_N = 1'b0; PIPE_STALL = 1'b0; Req = 1'b0; ERET = 1'b0;
        InstrAddr = BASE; im_ack = 1'b0; im_rdata = '0;
        pc = BASE; redir_target = BASE; cur_redir = 0;
        mem_busy = 0; mem_left = 0; mem_data = '0; fixed_data = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Idle cycle, then zero-wait streaming from 0x3000.
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive_eval(0, 0, 0, 0);
            check("zw_im_addr", im_addr, BASE + 32'(4 * i));
            check("zw_f_valid", 32'(F_valid), 32'd1);
            check("zw_stall_en_n", 32'(STALL_EN_N), 32'd1);
            advance();
        end

        // Two wait cycles, then the word is delivered.
        fixed_valid = 1; fixed_data = 32'h2408_0001;
        for (int i = 0; i < 2; i++) begin
            drive_eval(0, 0, 0, 2);
            check("w2_stall_en_n", 32'(STALL_EN_N), 32'd0);
            check("w2_f_valid", 32'(F_valid), 32'd0);
            advance();
        end
        drive_eval(0, 0, 0, 2);
        check("w2_f_instr", F_instr, 32'h2408_0001);
        check("w2_f_valid", 32'(F_valid), 32'd1);
        advance();

        // Ack under a 3-cycle stall: the word is held until the stall drops.
        fixed_data = 32'h1234_5678;
        step(1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            drive_eval(1, 0, 0, 0);
            check("hold_f_instr", F_instr, 32'h1234_5678);
            check("hold_stall_en_n", 32'(STALL_EN_N), 32'd0);
            advance();
        end
        drive_eval(0, 0, 0, 0);
        check("hold_exit_stall_en_n", 32'(STALL_EN_N), 32'd1);
        check("hold_exit_f_valid", 32'(F_valid), 32'd1);
        advance();
        fixed_valid = 0;

        // Redirect one cycle into a 3-wait fetch; the stale request drains.
        old_pc = pc;
        step(0, 0, 0, 3);
        redir_target = 32'h0000_3400;
        drive_eval(0, 1, 0, 3);
        check("rd_stall_en_n", 32'(STALL_EN_N), 32'd1);
        check("rd_f_valid", 32'(F_valid), 32'd0);
        advance();
        for (int i = 0; i < 2; i++) begin
            drive_eval(0, 0, 0, 3);
            check("drain_im_addr", im_addr, old_pc);
            check("drain_f_valid", 32'(F_valid), 32'd0);
            advance();
        end
        drive_eval(0, 0, 0, 0);
        check("rd_new_im_addr", im_addr, 32'h0000_3400);
        advance();

        // Misaligned and out-of-range PCs.
        redir_target = 32'h0000_3002;
        step(0, 1, 0, 0);
        drive_eval(0, 0, 0, 0);
        check("adel1_im_req", 32'(im_req), 32'd0);
        check("adel1_flag", 32'(F_exc_adel), 32'd1);
        check("adel1_f_instr", F_instr, 32'd0);
        advance();
        redir_target = 32'h0000_0000;
        step(0, 0, 1, 0);
        drive_eval(0, 0, 0, 0);
        check("adel2_im_req", 32'(im_req), 32'd0);
        check("adel2_flag", 32'(F_exc_adel), 32'd1);
        check("adel2_f_instr", F_instr, 32'd0);
        advance();

        // Silent memory: bus error on the 4th request cycle, then DRAIN, reset.
        do_reset();
        step(0, 0, 0, NO_ACK);
        for (int i = 0; i < 3; i++) step(0, 0, 0, NO_ACK);
        drive_eval(0, 0, 0, NO_ACK);
        check("tmo_f_exc_ibe", 32'(F_exc_ibe), 32'd1);
        check("tmo_f_instr", F_instr, 32'd0);
        advance();
        for (int i = 0; i < 2; i++) begin
            drive_eval(0, 0, 0, NO_ACK);
            check("tmo_drain_im_req", 32'(im_req), 32'd1);
            advance();
        end
        do_reset();

        // Randomized traffic.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit st, rq, er;
            int lat;
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                st  = ($urandom_range(0, 3) == 0);
                rq  = ($urandom_range(0, 19) == 0);
                er  = ($urandom_range(0, 24) == 0);
                lat = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : 0;
                redir_target = pick_target();
                step(st, rq, er, lat);
            end
        end

        $display("coverage: IDLE=%0d FETCH=%0d HOLD=%0d DRAIN=%0d",
                 state_hits[int'(ST_IDLE)], state_hits[int'(ST_FETCH)],
                 state_hits[int'(ST_HOLD)], state_hits[int'(ST_DRAIN)]);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
